// File: rtl/fp_acc_round_if.sv
// fp_acc_round_if: sample-in / result-out valid-ready bundle for fp_acc_round.
interface fp_acc_round_if #(parameter int IW = 13, parameter int OW = 11);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_sat;
  logic          out_ovf;
  modport master (output in_valid, in_data, in_ovf, out_ready,
                  input  in_ready, out_valid, out_data, out_sat, out_ovf);
  modport slave  (input  in_valid, in_data, in_ovf, out_ready,
                  output in_ready, out_valid, out_data, out_sat, out_ovf);
endinterface

// File: rtl/fp_acc_round.sv
// fp_acc_round: accumulate ACC_LEN fixed-point samples, round to OUT_FRAC bits and saturate.
// Define FP_ACC_RNE_EN for round-half-to-even; otherwise round-half-up.
module fp_acc_round #(
  parameter int IN_INT    = 8,
  parameter int IN_FRAC   = 5,
  parameter int OUT_INT   = 8,
  parameter int OUT_FRAC  = 3,
  parameter int ACC_LEN   = 4,
  parameter int ACC_GUARD = 2
) (
  input logic clk,
  input logic rst,
  fp_acc_round_if.slave bus
);
  localparam int IW = IN_INT + IN_FRAC;
  localparam int OW = OUT_INT + OUT_FRAC;
  localparam int AW = IW + ACC_GUARD;
  localparam int SH = IN_FRAC - OUT_FRAC;
  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, RND = 2'd2, HOLD = 2'd3;
  localparam logic signed [AW:0] MAXV = (AW+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [AW:0] MINV = -MAXV - (AW+1)'(1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic signed [AW-1:0] acc, in_sext;
  logic signed [AW:0] accx, r;
  logic ovf, accept, last, sat_hi, sat_lo;
  logic [OW-1:0] rd;
  assign bus.in_ready = rst && (state == IDLE || state == ACC);
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt == CW'(ACC_LEN - 1);
  assign in_sext = AW'($signed(bus.in_data));
  // one extra MSB so the rounding carry can never wrap
  assign accx = {acc[AW-1], acc};
`ifdef FP_ACC_RNE_EN
  localparam logic [SH-1:0] HALF_D = SH'(1) << (SH - 1);
  logic signed [AW:0] trunc;
  logic [SH-1:0] disc;
  logic up;
  assign trunc = accx >>> SH;
  assign disc = acc[SH-1:0];
  assign up = (disc > HALF_D) || (disc == HALF_D && acc[SH]);
  assign r = trunc + (AW+1)'(up);
`else
  localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (SH - 1);
  assign r = (accx + HALF) >>> SH;
`endif
  assign sat_hi = r > MAXV;
  assign sat_lo = r < MINV;
  assign rd = sat_hi ? MAXV[OW-1:0] : sat_lo ? MINV[OW-1:0] : r[OW-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc   <= in_sext;
          cnt   <= CW'(1);
          ovf   <= bus.in_ovf;
          state <= (ACC_LEN == 1) ? RND : ACC;
        end
        ACC: if (accept) begin
          acc   <= acc + in_sext;
          cnt   <= cnt + CW'(1);
          ovf   <= ovf | bus.in_ovf;
          state <= last ? RND : ACC;
        end
        RND: begin
          bus.out_data  <= rd;
          bus.out_sat   <= sat_hi || sat_lo;
          bus.out_ovf   <= ovf;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        default: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_acc_round.sv
// tb_fp_acc_round: scoreboard bench; a negedge monitor models each accepted group and checks every result handshake.
module tb_fp_acc_round;
  localparam int N = 4;
  localparam int SH = 2;
  localparam int MAXO = 1023;
  localparam int MINO = -1024;
  typedef struct { int v; bit s; bit o; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  int grp_sum = 0;
  int grp_n = 0;
  bit grp_ovf = 1'b0;
  bit rnd_rdy = 1'b0;
  fp_acc_round_if #(.IW(13), .OW(11)) bus ();
  fp_acc_round dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic void model(input int sum, output int v, output bit s);
    real x, f, d;
    x = real'(sum) / real'(1 << SH);
    f = $floor(x);
    d = x - f;
`ifdef FP_ACC_RNE_EN
    if (d > 0.5 || (d == 0.5 && (int'(f) % 2) != 0)) f = f + 1.0;
`else
    if (d >= 0.5) f = f + 1.0;
`endif
    v = int'(f);
    s = (v > MAXO) || (v < MINO);
    v = v > MAXO ? MAXO : v < MINO ? MINO : v;
  endfunction
  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      grp_sum = 0;
      grp_n = 0;
      grp_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", int'($signed(bus.out_data)), e.v);
          chk("out_sat", int'(bus.out_sat), int'(e.s));
          chk("out_ovf", int'(bus.out_ovf), int'(e.o));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        grp_sum += int'($signed(bus.in_data));
        grp_ovf |= bus.in_ovf;
        grp_n++;
        if (grp_n == N) begin
          exp_t e;
          model(grp_sum, e.v, e.s);
          e.o = grp_ovf;
          exp_q.push_back(e);
          grp_sum = 0;
          grp_n = 0;
          grp_ovf = 1'b0;
        end
      end
    end
  end
  task automatic send(input int d, input bit o);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 13'(d);
    bus.in_ovf = o;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask
  task automatic send4(input int a, input int b, input int c, input int d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask
  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("wait_out_valid", int'(seen), 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_out_sat"}, int'(bus.out_sat), 0);
    chk({tag, "_out_ovf"}, int'(bus.out_ovf), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
  endtask
  initial begin
    int ev;
    bit es;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_ovf = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    send4(32, 32, 32, 32);
    @(negedge clk);
    chk("latency_rnd_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("latency_hold_valid", int'(bus.out_valid), 1);
    send4(1, 1, 4, 4);
    send4(-1, -1, -4, -4);
    send4(2047, 2047, 2047, 2047);
    send4(-2048, -2048, -2048, -2048);
    send(10, 1'b0);
    send(10, 1'b1);
    send(10, 1'b0);
    send(10, 1'b0);
    send4(10, 10, 10, 10);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send4(5, 6, 7, 8);
    wait_valid();
    model(26, ev, es);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data = 13'(100 + i);
      @(negedge clk);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_out_data", int'($signed(bus.out_data)), ev);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_hs_in_ready", int'(bus.in_ready), 1);
    chk("after_hs_out_valid", int'(bus.out_valid), 0);
    send(32, 1'b0);
    send(32, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_acc_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    send4(32, 32, 32, 32);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send4(100, 100, 100, 100);
    wait_valid();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("hold_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 160; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send($urandom_range(0, 8191) - 4096, 1'($urandom_range(0, 7) == 0));
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_partial", grp_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
